bambu_slave_mem_master: RTL and testbench

- Initiator for the accelerator's slave memory port (S_oe_ram / S_we_ram / S_addr_ram / S_Wdata_ram / S_data_ram_size in; Sout_Rdata_ram / Sout_DataRdy back).
- Sits in the simulation/FPGA harness next to the HLS top.
- Lets a host-side sequencer preload inputs and read back results from the accelerator's internal memories through a simple valid/ready command/response channel.
- Drives lane 0 only; lane 1 is held at zero.

---
 rtl/bambu_slave_mem_master.sv | 222 ++++++++++++++++++++++
 tb/tb_bambu_slave_mem_master.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bambu_slave_mem_master.sv
// Master for the accelerator's slave memory port: runs one host command at a time on lane 0
// and returns a valid/ready response. Define BAMBU_SLAVE_MASTER_TIMEOUT_EN to bound the DataRdy wait.
module bambu_slave_mem_master #(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 64,
  parameter int SIZE_W   = 7,
  parameter int TIMEOUT  = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [SIZE_W-1:0]            cmd_size,
  input  logic [DATA_W-1:0]            cmd_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_err,
  output logic [CHANNELS-1:0]          S_oe_ram,
  output logic [CHANNELS-1:0]          S_we_ram,
  output logic [CHANNELS*ADDR_W-1:0]   S_addr_ram,
  output logic [CHANNELS*DATA_W-1:0]   S_Wdata_ram,
  output logic [CHANNELS*SIZE_W-1:0]   S_data_ram_size,
  input  logic [CHANNELS*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [CHANNELS-1:0]          Sout_DataRdy
);

  // state | meaning
  // IDLE  | cmd_ready high, waiting for a command
  // ISSUE | lane-0 request driven and held until DataRdy (or timeout)
  // RESP  | response held on rsp_* until rsp_ready
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              oe_q, oe_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] lane_addr_q, lane_addr_d;
  logic [SIZE_W-1:0] lane_size_q, lane_size_d;
  logic [DATA_W-1:0] lane_wdata_q, lane_wdata_d;
  logic              req_live;

`ifdef BAMBU_SLAVE_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT;
`endif

  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] sz);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < DATA_W; i++) m[i] = (i < int'(sz));
    return m;
  endfunction

  function automatic logic cmd_legal(input logic [SIZE_W-1:0] sz, input logic [ADDR_W-1:0] a);
    case (sz)
      SIZE_W'(8):  return 1'b1;
      SIZE_W'(16): return a[0] == 1'b0;
      SIZE_W'(32): return a[1:0] == 2'b00;
      SIZE_W'(64): return a[2:0] == 3'b000;
      default:     return 1'b0;
    endcase
  endfunction

  // The request becomes visible one cycle after entering ISSUE; DataRdy only counts once it is.
  assign req_live = oe_q | we_q;

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    oe_d         = oe_q;
    we_d         = we_q;
    lane_addr_d  = lane_addr_q;
    lane_size_d  = lane_size_q;
    lane_wdata_d = lane_wdata_q;
`ifdef BAMBU_SLAVE_MASTER_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          write_d     = cmd_write;
          addr_d      = cmd_addr;
          size_d      = cmd_size;
          wdata_d     = cmd_wdata & size_mask(cmd_size);
`ifdef BAMBU_SLAVE_MASTER_TIMEOUT_EN
          cnt_d       = '0;
`endif
          if (cmd_legal(cmd_size, cmd_addr)) begin
            state_d = S_ISSUE;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end
        end
      end
      S_ISSUE: begin
        if (!req_live) begin
          oe_d         = ~write_q;
          we_d         = write_q;
          lane_addr_d  = addr_q;
          lane_size_d  = size_q;
          lane_wdata_d = wdata_q;
        end else if (Sout_DataRdy[0]) begin
          oe_d         = 1'b0;
          we_d         = 1'b0;
          lane_addr_d  = '0;
          lane_size_d  = '0;
          lane_wdata_d = '0;
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b0;
          rsp_data_d   = write_q ? '0 : (Sout_Rdata_ram[DATA_W-1:0] & size_mask(size_q));
        end
`ifdef BAMBU_SLAVE_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          oe_d         = 1'b0;
          we_d         = 1'b0;
          lane_addr_d  = '0;
          lane_size_d  = '0;
          lane_wdata_d = '0;
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b1;
          rsp_data_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      oe_q         <= 1'b0;
      we_q         <= 1'b0;
      lane_addr_q  <= '0;
      lane_size_q  <= '0;
      lane_wdata_q <= '0;
`ifdef BAMBU_SLAVE_MASTER_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      oe_q         <= oe_d;
      we_q         <= we_d;
      lane_addr_q  <= lane_addr_d;
      lane_size_q  <= lane_size_d;
      lane_wdata_q <= lane_wdata_d;
`ifdef BAMBU_SLAVE_MASTER_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_err         = rsp_err_q;
  assign S_oe_ram        = {{(CHANNELS-1){1'b0}}, oe_q};
  assign S_we_ram        = {{(CHANNELS-1){1'b0}}, we_q};
  assign S_addr_ram      = {{((CHANNELS-1)*ADDR_W){1'b0}}, lane_addr_q};
  assign S_Wdata_ram     = {{((CHANNELS-1)*DATA_W){1'b0}}, lane_wdata_q};
  assign S_data_ram_size = {{((CHANNELS-1)*SIZE_W){1'b0}}, lane_size_q};

  // Lane 1 is never used by this master.
  logic unused_lanes;
  assign unused_lanes = ^{Sout_Rdata_ram[CHANNELS*DATA_W-1:DATA_W], Sout_DataRdy[CHANNELS-1:1]};

endmodule

// File: tb/tb_bambu_slave_mem_master.sv
// Bench for bambu_slave_mem_master: directed vector table, random commands against a reference
// model, and hand sequences for backpressure, reset mid-request and (with the macro) timeout.
module tb_bambu_slave_mem_master;
  localparam int CH = 2;
  localparam int AW = 9;
  localparam int DW = 64;
  localparam int SW = 7;
`ifdef BAMBU_SLAVE_MASTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic               clock;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [AW-1:0]      cmd_addr;
  logic [SW-1:0]      cmd_size;
  logic [DW-1:0]      cmd_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic [CH-1:0]      S_oe_ram;
  logic [CH-1:0]      S_we_ram;
  logic [CH*AW-1:0]   S_addr_ram;
  logic [CH*DW-1:0]   S_Wdata_ram;
  logic [CH*SW-1:0]   S_data_ram_size;
  logic [CH*DW-1:0]   Sout_Rdata_ram;
  logic [CH-1:0]      Sout_DataRdy;

  bambu_slave_mem_master #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Slave: raises DataRdy[0] in the rdy_delay-th cycle the request is visible.
  int   rdy_delay = 1;
  int   req_cnt   = 0;
  logic rdy_noise = 1'b0;
  always @(negedge clock) begin
    Sout_DataRdy[1] = 1'($urandom_range(0, 1));
    if (S_oe_ram[0] || S_we_ram[0]) begin
      req_cnt++;
      Sout_DataRdy[0] = (req_cnt == rdy_delay);
    end else begin
      req_cnt = 0;
      Sout_DataRdy[0] = rdy_noise;
    end
  end

  int            bus_cycles = 0;
  logic [AW-1:0] mon_addr;
  logic [SW-1:0] mon_size;
  logic [DW-1:0] mon_wd;
  logic          mon_we, mon_oe;
  bit            stable_bad = 0;
  bit            lane1_bad  = 0;
  always @(negedge clock) begin
    if (S_addr_ram[CH*AW-1:AW] != '0 || S_Wdata_ram[CH*DW-1:DW] != '0 ||
        S_data_ram_size[CH*SW-1:SW] != '0 || S_oe_ram[1] || S_we_ram[1])
      lane1_bad = 1;
    if (S_oe_ram[0] || S_we_ram[0]) begin
      if (bus_cycles > 0 && {mon_addr, mon_size, mon_wd, mon_we, mon_oe} !==
          {S_addr_ram[AW-1:0], S_data_ram_size[SW-1:0], S_Wdata_ram[DW-1:0], S_we_ram[0], S_oe_ram[0]})
        stable_bad = 1;
      mon_addr = S_addr_ram[AW-1:0];
      mon_size = S_data_ram_size[SW-1:0];
      mon_wd   = S_Wdata_ram[DW-1:0];
      mon_we   = S_we_ram[0];
      mon_oe   = S_oe_ram[0];
      bus_cycles++;
    end
  end

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [SW-1:0] s;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    int            d;
    logic          exp_err;
    logic [DW-1:0] exp_data;
    int            exp_lat;
    int            exp_bus;
    logic [DW-1:0] exp_wd;
  } vec_t;

  function automatic bit ref_legal(input int size, input int addr);
    if (!(size inside {8, 16, 32, 64})) return 0;
    return (addr % (size / 8)) == 0;
  endfunction

  function automatic logic [63:0] ref_trunc(input int size, input logic [63:0] v);
    if (size >= 64) return v;
    return v % (64'd1 << size);
  endfunction

  task automatic wait_ready(input string name);
    int g = 0;
    @(negedge clock);
    while (!cmd_ready && g < 50) begin
      @(negedge clock);
      g++;
    end
    if (g >= 50) chk({name, "_ready_timeout"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic drive_cmd(input logic w, input logic [AW-1:0] a, input logic [SW-1:0] s,
                           input logic [DW-1:0] wd);
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_wdata = {$urandom, $urandom};
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic ack(input string name);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    chk({name, "_valid_drop"}, 64'(rsp_valid), 64'd0);
    chk({name, "_ready_back"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    wait_ready(name);
    rdy_delay      = v.d;
    Sout_Rdata_ram = {$urandom, $urandom, v.rd};
    bus_cycles     = 0;
    stable_bad     = 0;
    drive_cmd(v.w, v.a, v.s, v.wd);
    wait_rsp(lat);
    chk({name, "_lat"}, 64'(lat), 64'(v.exp_lat));
    chk({name, "_err"}, 64'(rsp_err), 64'(v.exp_err));
    chk({name, "_data"}, rsp_data, v.exp_data);
    chk({name, "_bus_cycles"}, 64'(bus_cycles), 64'(v.exp_bus));
    if (!v.exp_err) begin
      chk({name, "_stable"}, 64'(stable_bad), 64'd0);
      chk({name, "_addr"}, 64'(mon_addr), 64'(v.a));
      chk({name, "_size"}, 64'(mon_size), 64'(v.s));
      chk({name, "_we_oe"}, 64'({mon_we, mon_oe}), 64'({v.w, ~v.w}));
      if (v.w) chk({name, "_wdata"}, mon_wd, v.exp_wd);
    end
    ack(name);
  endtask

  vec_t vecs[12];

  initial begin : main
    int   lat;
    bit   bad;
    logic [DW-1:0] snap;
    vec_t r;
    int   sizes[5];

    vecs[0]  = '{1'b1, 9'h010, 7'd32, 64'hFFFF_FFFF_DEAD_BEEF, 64'h0, 3, 1'b0, 64'h0, 4, 3, 64'h0000_0000_DEAD_BEEF};
    vecs[1]  = '{1'b0, 9'h011, 7'd8,  64'h0, 64'h1122_3344_5566_77AB, 1, 1'b0, 64'hAB, 2, 1, 64'h0};
    vecs[2]  = '{1'b1, 9'h020, 7'd24, 64'h1234, 64'h0, 1, 1'b1, 64'h0, 0, 0, 64'h0};
    vecs[3]  = '{1'b0, 9'h002, 7'd32, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1, 64'h0, 0, 0, 64'h0};
    vecs[4]  = '{1'b0, 9'h008, 7'd64, 64'h0, 64'h0123_4567_89AB_CDEF, 2, 1'b0, 64'h0123_4567_89AB_CDEF, 3, 2, 64'h0};
    vecs[5]  = '{1'b0, 9'h006, 7'd16, 64'h0, 64'hCAFE_BABE_1234_5678, 1, 1'b0, 64'h5678, 2, 1, 64'h0};
    vecs[6]  = '{1'b0, 9'h003, 7'd16, 64'h0, 64'h1111, 1, 1'b1, 64'h0, 0, 0, 64'h0};
    vecs[7]  = '{1'b1, 9'h1F8, 7'd64, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0, 1, 1'b0, 64'h0, 2, 1, 64'hA5A5_5A5A_0F0F_F0F0};
    vecs[8]  = '{1'b0, 9'h000, 7'd0,  64'h0, 64'hFF, 1, 1'b1, 64'h0, 0, 0, 64'h0};
    vecs[9]  = '{1'b0, 9'h004, 7'd64, 64'h0, 64'h77, 1, 1'b1, 64'h0, 0, 0, 64'h0};
    vecs[10] = '{1'b1, 9'h01E, 7'd16, 64'hFFFF_FFFF_FFFF_1234, 64'h0, 4, 1'b0, 64'h0, 5, 4, 64'h1234};
    vecs[11] = '{1'b0, 9'h00C, 7'd32, 64'h0, 64'h8000_0001_FEDC_BA98, 1, 1'b0, 64'hFEDC_BA98, 2, 1, 64'h0};
    sizes = '{8, 16, 32, 64, 0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; Sout_Rdata_ram = '0; Sout_DataRdy = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_bus", 64'({S_oe_ram, S_we_ram}), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_release_ready", 64'(cmd_ready), 64'd1);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Random commands scored by the reference model.
    for (int n = 0; n < 40; n++) begin
      r.w  = 1'($urandom_range(0, 1));
      r.s  = SW'(sizes[$urandom_range(0, 4)]);
      if (r.s == 0) r.s = SW'($urandom_range(0, 127));
      r.a  = AW'($urandom_range(0, 511));
      r.wd = {$urandom, $urandom};
      r.rd = {$urandom, $urandom};
      r.d  = $urandom_range(1, 4);
      r.exp_err  = !ref_legal(int'(r.s), int'(r.a));
      r.exp_data = (r.exp_err || r.w) ? 64'h0 : ref_trunc(int'(r.s), r.rd);
      r.exp_lat  = r.exp_err ? 0 : r.d + 1;
      r.exp_bus  = r.exp_err ? 0 : r.d;
      r.exp_wd   = ref_trunc(int'(r.s), r.wd);
      run_vec($sformatf("rnd%0d", n), r);
    end

    // Response backpressure with a second command waiting and noise on DataRdy.
    wait_ready("bp");
    rdy_delay = 2;
    Sout_Rdata_ram = {64'hDEAD_DEAD_DEAD_DEAD, 64'h0BAD_F00D_1357_9BDF};
    bus_cycles = 0;
    drive_cmd(1'b0, 9'h020, 7'd32, 64'h0);
    wait_rsp(lat);
    chk("bp_lat", 64'(lat), 64'd3);
    chk("bp_data", rsp_data, 64'h1357_9BDF);
    snap = 64'h1357_9BDF;
    cmd_write = 1'b1; cmd_addr = 9'h030; cmd_size = 7'd16; cmd_wdata = 64'hABCD_EF01;
    cmd_valid = 1'b1;
    rdy_noise = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      if (rsp_valid !== 1'b1 || rsp_data !== snap || rsp_err !== 1'b0 || cmd_ready !== 1'b0) bad = 1;
    end
    chk("bp_hold_stable", 64'(bad), 64'd0);
    chk("bp_no_accept", 64'(bus_cycles), 64'd2);
    rdy_noise = 1'b0;
    rdy_delay = 1;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    bus_cycles = 0;
    chk("bp_valid_drop", 64'(rsp_valid), 64'd0);
    chk("bp_ready_back", 64'(cmd_ready), 64'd1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    chk("bp_second_accepted", 64'(cmd_ready), 64'd0);
    wait_rsp(lat);
    chk("bp2_lat", 64'(lat), 64'd2);
    chk("bp2_rsp", 64'({rsp_err, rsp_data}), 65'h0);
    chk("bp2_bus", 64'({mon_we, mon_addr, mon_wd[15:0]}), 64'({1'b1, 9'h030, 16'hEF01}));
    ack("bp2");

    // Reset while the request waits for a DataRdy that never comes.
    wait_ready("rst_mid");
    rdy_delay = 100000;
    drive_cmd(1'b0, 9'h040, 7'd64, 64'h0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mid_req_on", 64'(S_oe_ram[0]), 64'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_mid_bus_off", 64'({S_oe_ram, S_we_ram}), 64'd0);
    chk("rst_mid_outs", 64'({cmd_ready, rsp_valid}), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_mid_ready", 64'(cmd_ready), 64'd1);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #1;
      if (rsp_valid !== 1'b0 || S_oe_ram[0] !== 1'b0) bad = 1;
    end
    chk("rst_mid_quiet", 64'(bad), 64'd0);
    rdy_delay = 1;

`ifdef BAMBU_SLAVE_MASTER_TIMEOUT_EN
    r = '{1'b0, 9'h018, 7'd32, 64'h0, 64'h1234_5678, 100000, 1'b1, 64'h0, 17, 16, 64'h0};
    run_vec("timeout", r);
`endif

    chk("lane1_zero", 64'(lane1_bad), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule
